// File: rtl/pi_mem_arb.sv
// Arbitrates one external memory port between the CPU (priority) and the latched PI requester.
// Each grant is MEM_CYC strobe clocks plus one recovery clock; a PI request waits at most STARVE CPU grants.
module pi_mem_arb #(
  parameter int AW      = 24,
  parameter int MEM_CYC = 4,
  parameter int STARVE  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_dato,
  input  logic [1:0]    cpu_be,
  output logic [15:0]   cpu_dati,
  output logic          cpu_ack,
  input  logic          pi_req,
  input  logic          pi_we,
  input  logic [AW-1:0] pi_addr,
  input  logic [7:0]    pi_dato,
  output logic [7:0]    pi_dati,
  output logic          pi_busy,
  output logic [AW-2:0] mem_addr,
  output logic [15:0]   mem_dato,
  input  logic [15:0]   mem_dati,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [1:0]    mem_be
);

  localparam int              SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);
  localparam logic [3:0]      LAST       = 4'(MEM_CYC - 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, PI_ACC, RECOVER} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cyc_ctr;
  logic [SW-1:0] starve_ctr;
  logic          pi_pend;
  logic          pi_we_l;
  logic [AW-1:0] pi_addr_l;
  logic [7:0]    pi_dato_l;
  logic          acc_lo;
  logic          grant_cpu, grant_pi;
  logic          in_acc, acc_last, cpu_done, pi_done;
  logic          unused_cpu_a0;

  assign unused_cpu_a0 = cpu_addr[0];
  assign in_acc   = (state == CPU_ACC) || (state == PI_ACC);
  assign acc_last = in_acc && (cyc_ctr == LAST);
  assign cpu_done = acc_last && (state == CPU_ACC);
  assign pi_done  = acc_last && (state == PI_ACC);
  assign pi_busy  = pi_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // CPU wins unless a pending PI request has already been passed over STARVE times
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_pi  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && (!pi_pend || (starve_ctr < STARVE_MAX))) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_ACC;
        end else if (pi_pend) begin
          grant_pi  = 1'b1;
          state_nxt = PI_ACC;
        end
      end
      CPU_ACC, PI_ACC: if (acc_last) state_nxt = RECOVER;
      RECOVER:         state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_ctr    <= 4'd0;
      starve_ctr <= '0;
    end else begin
      if (in_acc && !acc_last) cyc_ctr <= cyc_ctr + 4'd1;
      else                     cyc_ctr <= 4'd0;
      if (state == IDLE) begin
        if (grant_pi || !pi_pend) starve_ctr <= '0;
        else if (grant_cpu)       starve_ctr <= starve_ctr + SW'(1);
      end
    end
  end

  // Memory port is fully registered at grant and held until the last access clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_dato <= 16'h0000;
      mem_be   <= 2'b00;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      acc_lo   <= 1'b0;
    end else if (grant_cpu) begin
      mem_addr <= cpu_addr[AW-1:1];
      mem_dato <= cpu_dato;
      mem_be   <= cpu_be;
      mem_oe   <= ~cpu_we;
      mem_we   <= cpu_we;
    end else if (grant_pi) begin
      mem_addr <= pi_addr_l[AW-1:1];
      mem_dato <= pi_addr_l[0] ? {8'h00, pi_dato_l} : {pi_dato_l, 8'h00};
      mem_be   <= pi_addr_l[0] ? 2'b01 : 2'b10;
      mem_oe   <= ~pi_we_l;
      mem_we   <= pi_we_l;
      acc_lo   <= pi_addr_l[0];
    end else if (acc_last) begin
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack  <= 1'b0;
      cpu_dati <= 16'h0000;
      pi_dati  <= 8'hFF;
    end else begin
      cpu_ack <= cpu_done;
      if (cpu_done && mem_oe) cpu_dati <= mem_dati;
      if (pi_done && mem_oe)  pi_dati  <= acc_lo ? mem_dati[7:0] : mem_dati[15:8];
    end
  end

  // A new pi_req always wins over completion so a back-to-back request is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_pend   <= 1'b0;
      pi_we_l   <= 1'b0;
      pi_addr_l <= '0;
      pi_dato_l <= 8'h00;
    end else if (pi_req) begin
      pi_pend   <= 1'b1;
      pi_we_l   <= pi_we;
      pi_addr_l <= pi_addr;
      pi_dato_l <= pi_dato;
    end else if (pi_done) begin
      pi_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pi_mem_arb.sv
// Directed bench for pi_mem_arb: table of single accesses plus hand-written multi-cycle sequences.
module tb_pi_mem_arb;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_ack, pi_req, pi_we, pi_busy, mem_oe, mem_we;
  logic [AW-1:0] cpu_addr, pi_addr;
  logic [15:0]   cpu_dato, cpu_dati, mem_dato, mem_dati;
  logic [1:0]    cpu_be, mem_be;
  logic [7:0]    pi_dato, pi_dati;
  logic [AW-2:0] mem_addr;

  always #5 clk = ~clk;

  pi_mem_arb #(.AW(AW), .MEM_CYC(4), .STARVE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dato(cpu_dato),
    .cpu_be(cpu_be), .cpu_dati(cpu_dati), .cpu_ack(cpu_ack),
    .pi_req(pi_req), .pi_we(pi_we), .pi_addr(pi_addr), .pi_dato(pi_dato),
    .pi_dati(pi_dati), .pi_busy(pi_busy),
    .mem_addr(mem_addr), .mem_dato(mem_dato), .mem_dati(mem_dati),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_be(mem_be)
  );

  typedef struct {
    logic          is_pi;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdat;
    logic [1:0]    be;
    logic [15:0]   mdati;
    logic [AW-2:0] e_addr;
    logic [15:0]   e_dato;
    logic [1:0]    e_be;
    logic [15:0]   e_rd;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] pi_rd_m  = 8'hFF;
  logic [15:0] cpu_rd_m = 16'h0000;
  bit         ovl = 1'b0;
  vec_t       vecs[8];

  always @(negedge clk) if (mem_oe && mem_we) ovl = 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int strb = 0;
    bit done = 1'b0;
    mem_dati = v.mdati;
    @(negedge clk);
    if (v.is_pi) begin
      pi_req = 1'b1; pi_we = v.we; pi_addr = v.addr; pi_dato = v.wdat[7:0];
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_dato = v.wdat; cpu_be = v.be;
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      pi_req = 1'b0;
      if (mem_oe || mem_we) begin
        if (strb == 0) begin
          chk("vec_addr", 32'(mem_addr), 32'(v.e_addr));
          chk("vec_be", 32'(mem_be), 32'(v.e_be));
          chk("vec_we", 32'(mem_we), 32'(v.we));
          chk("vec_oe", 32'(mem_oe), 32'(!v.we));
          if (v.we) chk("vec_dato", 32'(mem_dato), 32'(v.e_dato));
          if (v.is_pi) chk("vec_busy_hi", 32'(pi_busy), 32'd1);
          else         chk("vec_ack_early", 32'(cpu_ack), 32'd0);
        end
        strb++;
      end else if (strb != 0) begin
        done = 1'b1;
        chk("vec_strobe_len", strb, 32'd4);
        if (v.is_pi) begin
          if (!v.we) pi_rd_m = v.e_rd[7:0];
          chk("vec_busy_clr", 32'(pi_busy), 32'd0);
          chk("vec_pi_dati", 32'(pi_dati), 32'(pi_rd_m));
        end else begin
          if (!v.we) cpu_rd_m = v.e_rd;
          chk("vec_cpu_ack", 32'(cpu_ack), 32'd1);
          chk("vec_cpu_dati", 32'(cpu_dati), 32'(cpu_rd_m));
          cpu_req = 1'b0;
        end
      end
    end
    if (!done) chk("vec_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int acks, t, pi_pos, grants, after_cpu, strb, phase;
    int ts[3];
    bit prev, cur, busy_gap, done, ack_seen, strb_seen;

    vecs[0] = '{1'b1, 1'b1, 25'h1080003, 16'h005A, 2'b00, 16'h0000, 24'h840001, 16'h005A, 2'b01, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 25'h0000000, 16'h0000, 2'b00, 16'hBEEF, 24'h000000, 16'h0000, 2'b10, 16'h00BE};
    vecs[2] = '{1'b1, 1'b0, 25'h0000101, 16'h0000, 2'b00, 16'h1234, 24'h000080, 16'h0000, 2'b01, 16'h0034};
    vecs[3] = '{1'b1, 1'b1, 25'h00000FE, 16'h00A5, 2'b00, 16'h0000, 24'h00007F, 16'hA500, 2'b10, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 25'h0ABCDEE, 16'hC0DE, 2'b11, 16'h0000, 24'h55E6F7, 16'hC0DE, 2'b11, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 25'h0000010, 16'h0000, 2'b11, 16'h5AA5, 24'h000008, 16'h0000, 2'b11, 16'h5AA5};
    vecs[6] = '{1'b0, 1'b0, 25'h1FFFFFF, 16'h0000, 2'b01, 16'h8001, 24'hFFFFFF, 16'h0000, 2'b01, 16'h8001};
    vecs[7] = '{1'b0, 1'b1, 25'h0000003, 16'h1234, 2'b10, 16'h0000, 24'h000001, 16'h1234, 2'b10, 16'h0000};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dato = 16'h0; cpu_be = 2'b00;
    pi_req = 1'b0; pi_we = 1'b0; pi_addr = '0; pi_dato = 8'h0; mem_dati = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_dati", 32'(cpu_dati), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_pi_dati", 32'(pi_dati), 32'hFF);
    chk("rst_pi_busy", 32'(pi_busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_dato", 32'(mem_dato), 32'd0);
    chk("rst_mem_strobes", 32'({mem_oe, mem_we}), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // CPU back-to-back reads: acks every MEM_CYC + 2 clocks
    mem_dati = 16'h4242;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000040; cpu_be = 2'b11;
    acks = 0; t = 0;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      @(negedge clk);
      t++;
      if (cpu_ack) begin ts[acks] = t; acks++; end
    end
    cpu_req = 1'b0;
    chk("b2b_acks", acks, 32'd3);
    chk("b2b_gap1", ts[1] - ts[0], 32'd6);
    chk("b2b_gap2", ts[2] - ts[1], 32'd6);
    chk("b2b_dati", 32'(cpu_dati), 32'h4242);
    repeat (3) @(negedge clk);

    // Starvation: continuous CPU load, one PI read posted during the first CPU access
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100;
    @(negedge clk);
    @(negedge clk);
    pi_req = 1'b1; pi_we = 1'b0; pi_addr = 25'h0200000;
    prev = mem_oe | mem_we;
    pi_pos = -1; grants = 0; after_cpu = 0;
    for (int c = 0; c < 80 && grants < 5; c++) begin
      @(negedge clk);
      pi_req = 1'b0;
      cur = mem_oe | mem_we;
      if (cur && !prev) begin
        if (mem_addr == 24'h100000) begin
          if (pi_pos < 0) pi_pos = grants;
        end else if (pi_pos >= 0 && after_cpu == 0) begin
          after_cpu = 1;
          chk("starve_ctr_clr", 32'(dut.starve_ctr), 32'd0);
        end
        grants++;
      end
      prev = cur;
    end
    chk("starve_cpu_grants", pi_pos, 32'd3);
    chk("starve_cpu_resume", after_cpu, 32'd1);
    cpu_req = 1'b0;
    repeat (8) @(negedge clk);

    // Collision: second pi_req in the completion clock of the first PI access
    mem_dati = 16'h1111;
    @(negedge clk);
    pi_req = 1'b1; pi_we = 1'b0; pi_addr = 25'h0000002;
    strb = 0; phase = 0; busy_gap = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      pi_req = 1'b0;
      if (mem_oe || mem_we) begin
        strb++;
        if (phase == 0 && strb == 4) begin pi_req = 1'b1; pi_addr = 25'h0000005; end
        if (phase == 1 && strb == 1) chk("coll_addr2", 32'(mem_addr), 32'h2);
      end else if (strb != 0) begin
        if (phase == 0) begin
          chk("coll_dati1", 32'(pi_dati), 32'h11);
          mem_dati = 16'h2233;
          phase = 1; strb = 0;
        end else begin
          chk("coll_dati2", 32'(pi_dati), 32'h33);
          chk("coll_busy_end", 32'(pi_busy), 32'd0);
          done = 1'b1;
        end
      end
      if (!done && !pi_busy) busy_gap = 1'b1;
    end
    chk("coll_done", 32'(done), 32'd1);
    chk("coll_no_gap", 32'(busy_gap), 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000200; cpu_dato = 16'h7777; cpu_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_we_before", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobes", 32'({mem_oe, mem_we}), 32'd0);
    chk("rstmid_pi_dati", 32'(pi_dati), 32'hFF);
    chk("rstmid_ack", 32'(cpu_ack), 32'd0);
    ack_seen = 1'b0; strb_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) ack_seen = 1'b1;
    end
    cpu_req = 1'b0;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack) ack_seen = 1'b1;
      if (mem_oe || mem_we) strb_seen = 1'b1;
    end
    chk("rstmid_no_ack", 32'(ack_seen), 32'd0);
    chk("rstmid_no_strobe", 32'(strb_seen), 32'd0);

    chk("oe_we_overlap", 32'(ovl), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
